fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_prefetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, buffers DEPTH words, and feeds the IF/ID register.
// An acked word reaches instr_out two or more edges later; freeze holds IF/ID while the queue keeps filling, and fetch stops when the queue is full.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DISCARD} state_t;

  state_t        state, state_d;
  logic [31:0]   pc, pc_d, addr_d, br_tgt, next_pc;
  logic          req_d, push, pop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_d, count_inc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  assign br_tgt  = br_addr & 32'hFFFF_FFFC;
  assign next_pc = pc + 32'd4;
  // Pop only against the registered count, so a word pushed this edge cannot be popped this edge.
  assign pop       = !br_taken && !freeze && (count != '0);
  assign count_inc = count + (PW+1)'(1) - (PW+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = imem_req;
    addr_d  = imem_addr;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (br_taken) begin
          pc_d = br_tgt;
        end else if (count < FULL) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (br_taken) begin
          pc_d = br_tgt;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DISCARD;
          end
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = next_pc;
          // imem_addr equals pc here, so next_pc is also the follow-on fetch address.
          if (count_inc < FULL) begin
            addr_d = next_pc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_DISCARD: begin
        if (br_taken) pc_d = br_tgt;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (br_taken) count_d = '0;
    else          count_d = count + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      instr_out   <= 32'd0;
      pc_out      <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      count     <= count_d;
      if (br_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (br_taken) begin
        instr_out   <= 32'd0;
        instr_valid <= 1'b0;
      end else if (!freeze) begin
        if (pop) begin
          instr_out   <= q_instr[rd_ptr];
          pc_out      <= q_pc[rd_ptr];
          instr_valid <= 1'b1;
        end else begin
          instr_out   <= 32'd0;
          instr_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a memory model answers requests, a scoreboard checks every word entering IF/ID.
module tb_fetch_prefetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acks_left = 0;
  int   mem_lat = 0;
  int   wait_cnt = 0;
  bit   inject_ack = 1'b0;
  logic upd = 1'b0;
  logic p_req = 1'b0;
  logic p_ack = 1'b0;
  logic [31:0] p_addr = 32'd0;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pc    = a + 32'd4;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, output int gaps);
    bit seen = 1'b0;
    bit done = 1'b0;
    gaps = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (instr_valid) seen = 1'b1;
      else if (seen && sb.size() != 0) gaps++;
      if (sb.size() == 0 && acks_left == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_%s: %0d words still expected, required 0", name, sb.size());
    end
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      got = instr_valid;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: instr_valid stayed 0, required 1", name);
    end
  endtask

  task automatic wait_new_addr(input string name, input logic [31:0] old_a, input logic [31:0] exp_a);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (imem_req && imem_addr != old_a) got = 1'b1;
    end
    if (got) check(name, imem_addr, exp_a);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no new request seen, required addr %h", name, exp_a);
    end
  endtask

  // Memory: answers a pending request after mem_lat wait cycles, at most acks_left more times.
  always begin
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (inject_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      inject_ack = 1'b0;
    end else if (rst) begin
      wait_cnt = 0;
    end else if (imem_req && acks_left > 0) begin
      if (wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        acks_left--;
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(posedge clk) upd <= !freeze || br_taken;

  // Monitor: scoreboard on each newly loaded valid word, plus request hold/stability.
  always @(negedge clk) begin
    if (rst) begin
      p_req = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (upd && instr_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got instr %h pc %h, required no output", instr_out, pc_out);
        end else begin
          mon_e = sb.pop_front();
          check("sb_instr", instr_out, mon_e.instr);
          check("sb_pc", pc_out, mon_e.pc);
        end
      end
      if (p_req && !p_ack) begin
        check_bit("req_held", imem_req, 1'b1);
        check("addr_stable", imem_addr, p_addr);
      end
      p_req  = imem_req;
      p_addr = imem_addr;
      p_ack  = imem_ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps;
    step();
    step();
    check_bit("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check_bit("rst_valid", instr_valid, 1'b0);

    // Zero-wait memory, no freeze: continuous stream from 0x0.
    mem_lat   = 0;
    acks_left = 8;
    for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
    rst = 1'b0;
    drain("zero_wait", gaps);
    check("zw_no_gaps", 32'(gaps), 32'd0);

    // Freeze six cycles while the queue fills to DEPTH.
    acks_left = 5;
    for (int i = 0; i < 5; i++) expect_word(32'h20 + 32'(i * 4));
    wait_valid("frz_first");
    freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("frz_hold_instr", instr_out, mem_word(32'h20));
      check("frz_hold_pc", pc_out, 32'h24);
      check_bit("frz_hold_valid", instr_valid, 1'b1);
    end
    check_bit("frz_full_no_req", imem_req, 1'b0);
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_bit("frz_no_bubble", instr_valid, 1'b1);
    end
    step();
    check_bit("frz_then_bubble", instr_valid, 1'b0);
    drain("freeze", gaps);

    // Three wait cycles per access: bubbles appear between words.
    mem_lat   = 3;
    acks_left = 3;
    expect_word(32'h34);
    expect_word(32'h38);
    expect_word(32'h3C);
    drain("lat3", gaps);
    check_bit("lat3_bubbles", gaps > 0, 1'b1);
    mem_lat = 0;

    // Branch while 0x40 is in flight, then branch to 0x40 while 0x10 is in flight.
    br_addr  = 32'h10;
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    check_bit("br1_bubble", instr_valid, 1'b0);
    check_bit("br1_req_held", imem_req, 1'b1);
    check("br1_addr_held", imem_addr, 32'h40);
    acks_left = 1;
    wait_new_addr("br1_redirect", 32'h40, 32'h10);
    br_addr  = 32'h40;
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    check_bit("br2_bubble", instr_valid, 1'b0);
    check("br2_addr_held", imem_addr, 32'h10);
    acks_left = 3;
    expect_word(32'h40);
    expect_word(32'h44);
    wait_new_addr("br2_redirect", 32'h10, 32'h40);
    drain("branch", gaps);

    // Branch coincident with ack under freeze: word dropped, bubble forced, queue flushed.
    acks_left = 3;
    expect_word(32'h48);
    wait_valid("bf_first");
    check_bit("bf_ack_coincide", imem_ack, 1'b1);
    freeze   = 1'b1;
    br_addr  = 32'h80;
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    check_bit("bf_bubble_valid", instr_valid, 1'b0);
    check("bf_bubble_instr", instr_out, 32'd0);
    check("bf_bubble_pc", pc_out, 32'h4C);
    check_bit("bf_idle", imem_req, 1'b0);
    step();
    check_bit("bf_reissue_req", imem_req, 1'b1);
    check("bf_reissue_addr", imem_addr, 32'h80);
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("bf_queue_empty", instr_valid, 1'b0);
    end
    drain("br_freeze", gaps);

    // Asynchronous reset in WAIT_ACK, stray ack afterwards, restart at RESET_PC.
    acks_left = 2;
    expect_word(32'h80);
    wait_valid("rst_first");
    #5;
    rst = 1'b1;
    #1;
    check_bit("arst_req", imem_req, 1'b0);
    check_bit("arst_valid", instr_valid, 1'b0);
    check("arst_instr", instr_out, 32'd0);
    check("arst_pc", pc_out, 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    step();
    inject_ack = 1'b1;
    step();
    rst       = 1'b0;
    acks_left = 2;
    expect_word(RESET_PC);
    expect_word(RESET_PC + 32'd4);
    step();
    check_bit("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, RESET_PC);
    drain("restart", gaps);

    // Back-to-back branches during discard, target at top of memory: PC wraps to 0.
    br_addr  = 32'h200;
    br_taken = 1'b1;
    step();
    br_addr = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    check_bit("disc_req_held", imem_req, 1'b1);
    check("disc_addr_held", imem_addr, 32'h8);
    acks_left = 3;
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0);
    wait_new_addr("wrap_redirect", 32'h8, 32'hFFFF_FFFC);
    drain("wrap", gaps);

    for (int i = 0; i < 4; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
